pipeline_hazard_ctrl: RTL and testbench

- Parametrised hazard and forwarding controller for the N-register in-order pipeline. It is the generalised successor of the fixed 4-register hazard unit.
- Keeps an internal shadow pipeline of per-stage metadata (valid, dest reg, sources, load/mem flags). From this it drives per-register enable/flush, PC enable, EX-operand forwarding selects and a sticky halt.
- Sits beside the datapath; all pipeline registers, the PC and the ALU operand muxes are steered from here.

---
 rtl/hazard_pkg.sv | 37 +++
 rtl/hazard_shadow_stage.sv | 24 ++
 rtl/pipeline_hazard_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: per-stage shadow metadata,
// forward-select encoding and the stall-cause priority used to decode the steering outputs.
package hazard_pkg;

  localparam int MAX_REG_W = 8;
  localparam int MAX_FWD_W = 3;

  typedef logic [MAX_FWD_W-1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_REGFILE = '0;

  typedef struct packed {
    logic                 valid;
    logic                 wen;
    logic [MAX_REG_W-1:0] wsel;
    logic [MAX_REG_W-1:0] rs;
    logic [MAX_REG_W-1:0] rt;
    logic                 is_load;
    logic                 is_mem;
  } stage_meta_t;

  // Listed in decreasing priority; the first active cause owns the cycle.
  typedef enum logic [2:0] {
    CAUSE_NONE,
    CAUSE_HALT,
    CAUSE_DMEM,
    CAUSE_LOADUSE,
    CAUSE_BRANCH,
    CAUSE_JUMP,
    CAUSE_IFETCH
  } stall_cause_t;

  function automatic logic src_hit(input stage_meta_t e, input logic [MAX_REG_W-1:0] src);
    return e.valid && e.wen && (src != '0) && (e.wsel == src);
  endfunction

endpackage

// File: rtl/hazard_shadow_stage.sv
// One shadow pipeline entry: clears on flush, loads on enable, holds otherwise.
// One-cycle latency; the caller's en/flush is the only backpressure.
module hazard_shadow_stage
  import hazard_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        en,
  input  logic        flush,
  input  stage_meta_t d,
  output stage_meta_t q
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      q <= '0;
    end else if (flush) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// N-register hazard/forwarding controller; steering outputs are combinational from the shadow
// pipeline and current inputs. HAZARD_FORWARDING_EN enables EX forwarding, else RAW stalls.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int NSTAGES = 4,
  parameter int REG_W   = 5,
  parameter int FWD_W   = $clog2(NSTAGES)
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               ihit,
  input  logic               dhit,
  input  logic               id_valid,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic               id_wen,
  input  logic [REG_W-1:0]   id_wsel,
  input  logic               id_is_load,
  input  logic               id_is_mem,
  input  logic               id_jump,
  input  logic               ex_br_taken,
  input  logic               wb_halt,
  output logic [NSTAGES-1:0] en,
  output logic [NSTAGES-1:0] flush,
  output logic               pc_en,
  output logic [FWD_W-1:0]   fwd_a,
  output logic [FWD_W-1:0]   fwd_b,
  output logic               halted
);

  stage_meta_t  id_meta;
  stage_meta_t  shadow [1:NSTAGES-1];
  stall_cause_t cause;
  logic         dmem_stall;
  logic         load_use;
  logic [MAX_REG_W-1:0] src_rs;
  logic [MAX_REG_W-1:0] src_rt;

  assign src_rs = MAX_REG_W'(id_rs);
  assign src_rt = MAX_REG_W'(id_rt);

  always_comb begin
    id_meta         = '0;
    id_meta.valid   = id_valid;
    id_meta.wen     = id_wen;
    id_meta.wsel    = MAX_REG_W'(id_wsel);
    id_meta.rs      = src_rs;
    id_meta.rt      = src_rt;
    id_meta.is_load = id_is_load;
    id_meta.is_mem  = id_is_mem;
  end

  for (genvar k = 1; k < NSTAGES; k++) begin : g_shadow
    stage_meta_t d;
    if (k == 1) begin : g_first
      assign d = id_meta;
    end else begin : g_next
      assign d = shadow[k-1];
    end
    hazard_shadow_stage u_stage (
      .CLK   (CLK),
      .nRST  (nRST),
      .en    (en[k]),
      .flush (flush[k]),
      .d     (d),
      .q     (shadow[k])
    );
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      halted <= 1'b0;
    end else if (wb_halt && shadow[NSTAGES-1].valid) begin
      halted <= 1'b1;
    end
  end

  assign dmem_stall = shadow[2].valid && shadow[2].is_mem && !dhit;

  always_comb begin
    load_use = 1'b0;
`ifdef HAZARD_FORWARDING_EN
    // Only loads still short of the last register are unforwardable.
    for (int j = 1; j <= NSTAGES-3; j++) begin
      if (shadow[j].is_load && (src_hit(shadow[j], src_rs) || src_hit(shadow[j], src_rt)))
        load_use = 1'b1;
    end
`else
    for (int j = 1; j < NSTAGES; j++) begin
      if (src_hit(shadow[j], src_rs) || src_hit(shadow[j], src_rt))
        load_use = 1'b1;
    end
`endif
    load_use = load_use && id_valid;
  end

  always_comb begin
    if (halted)           cause = CAUSE_HALT;
    else if (dmem_stall)  cause = CAUSE_DMEM;
    else if (load_use)    cause = CAUSE_LOADUSE;
    else if (ex_br_taken) cause = CAUSE_BRANCH;
    else if (id_jump)     cause = CAUSE_JUMP;
    else if (!ihit)       cause = CAUSE_IFETCH;
    else                  cause = CAUSE_NONE;
  end

  always_comb begin
    en    = '1;
    flush = '0;
    pc_en = 1'b1;
    case (cause)
      CAUSE_HALT: begin
        en    = '0;
        pc_en = 1'b0;
      end
      CAUSE_DMEM: begin
        en[2:0]  = 3'b000;
        flush[3] = 1'b1;
        pc_en    = 1'b0;
      end
      CAUSE_LOADUSE: begin
        en[0]    = 1'b0;
        flush[1] = 1'b1;
        pc_en    = 1'b0;
      end
      CAUSE_BRANCH: flush[1:0] = 2'b11;
      CAUSE_JUMP:   flush[0]   = 1'b1;
      CAUSE_IFETCH: begin
        flush[0] = 1'b1;
        pc_en    = 1'b0;
      end
      default: ;
    endcase
    if (!nRST) begin
      en    = '0;
      flush = '1;
      pc_en = 1'b0;
    end
  end

`ifdef HAZARD_FORWARDING_EN
  fwd_sel_t sel_a;
  fwd_sel_t sel_b;

  // Scan oldest to youngest so the lowest-index match overwrites the others.
  always_comb begin
    sel_a = FWD_REGFILE;
    sel_b = FWD_REGFILE;
    for (int k = NSTAGES-1; k >= 2; k--) begin
      if (!shadow[k].is_load || k == NSTAGES-1) begin
        if (src_hit(shadow[k], shadow[1].rs)) sel_a = fwd_sel_t'(k);
        if (src_hit(shadow[k], shadow[1].rt)) sel_b = fwd_sel_t'(k);
      end
    end
  end

  assign fwd_a = nRST ? FWD_W'(sel_a) : FWD_W'(FWD_REGFILE);
  assign fwd_b = nRST ? FWD_W'(sel_b) : FWD_W'(FWD_REGFILE);
`else
  assign fwd_a = FWD_W'(FWD_REGFILE);
  assign fwd_b = FWD_W'(FWD_REGFILE);
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl at NSTAGES=4 and NSTAGES=6 driven in lockstep against
// an instruction-level reference model; directed table plus hand sequences plus random traffic.
module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    bit ihit, dhit, idv, wen, ld, mem, jump, br, halt;
    int rs, rt, wsel;
  } in_t;

  typedef struct {
    bit v, wen, ld, mem;
    int wsel, rs, rt;
  } ins_t;

  typedef struct {
    int en, fl, fa, fb;
    bit pc;
  } out_t;

  typedef struct {
    in_t in;
    int  en, fl;
    bit  pc;
  } vec_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       nRST;
  logic       ihit, dhit, id_valid, id_wen, id_is_load, id_is_mem, id_jump, ex_br_taken, wb_halt;
  logic [4:0] id_rs, id_rt, id_wsel;

  logic [3:0] en4, flush4;
  logic [1:0] fa4, fb4;
  logic       pc4, h4;
  logic [5:0] en6, flush6;
  logic [2:0] fa6, fb6;
  logic       pc6, h6;

  int   checks = 0;
  int   errors = 0;
  ins_t sh [2][8];
  bit   mhalt [2];
  in_t  last_in;

  pipeline_hazard_ctrl #(.NSTAGES(4)) dut4 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_wen(id_wen), .id_wsel(id_wsel),
    .id_is_load(id_is_load), .id_is_mem(id_is_mem), .id_jump(id_jump),
    .ex_br_taken(ex_br_taken), .wb_halt(wb_halt), .en(en4), .flush(flush4),
    .pc_en(pc4), .fwd_a(fa4), .fwd_b(fb4), .halted(h4)
  );

  pipeline_hazard_ctrl #(.NSTAGES(6)) dut6 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_wen(id_wen), .id_wsel(id_wsel),
    .id_is_load(id_is_load), .id_is_mem(id_is_mem), .id_jump(id_jump),
    .ex_br_taken(ex_br_taken), .wb_halt(wb_halt), .en(en6), .flush(flush6),
    .pc_en(pc6), .fwd_a(fa6), .fwd_b(fb6), .halted(h6)
  );

  function automatic in_t idle();
    in_t r;
    r = '{default: 0};
    r.ihit = 1'b1;
    r.dhit = 1'b1;
    return r;
  endfunction

  function automatic vec_t mkvec(input in_t i, input int e, input int f, input bit p);
    vec_t v;
    v.in = i; v.en = e; v.fl = f; v.pc = p;
    return v;
  endfunction

  function automatic ins_t from_id(input in_t i);
    ins_t x;
    x.v = i.idv; x.wen = i.wen; x.ld = i.ld; x.mem = i.mem;
    x.wsel = i.wsel; x.rs = i.rs; x.rt = i.rt;
    return x;
  endfunction

  function automatic bit hit(input ins_t e, input int src);
    return e.v && e.wen && src != 0 && e.wsel == src;
  endfunction

  // Expected steering for one controller instance given its instruction window and this cycle's inputs.
  function automatic out_t model_out(input int d, input in_t in);
    int   n;
    int   all;
    bit   lu;
    bit   elig;
    out_t o;
    n   = (d == 0) ? 4 : 6;
    all = (1 << n) - 1;
    lu  = 1'b0;
    o.en = all; o.fl = 0; o.pc = 1'b1; o.fa = 0; o.fb = 0;
    for (int j = 1; j < n; j++) begin
      elig = FWD ? (j <= n - 3 && sh[d][j].ld) : 1'b1;
      if (elig && (hit(sh[d][j], in.rs) || hit(sh[d][j], in.rt))) lu = 1'b1;
    end
    if (mhalt[d]) begin
      o.en = 0; o.pc = 1'b0;
    end else if (sh[d][2].v && sh[d][2].mem && !in.dhit) begin
      o.en = all & ~7; o.fl = 8; o.pc = 1'b0;
    end else if (in.idv && lu) begin
      o.en = all & ~1; o.fl = 2; o.pc = 1'b0;
    end else if (in.br) begin
      o.fl = 3;
    end else if (in.jump) begin
      o.fl = 1;
    end else if (!in.ihit) begin
      o.fl = 1; o.pc = 1'b0;
    end
    if (FWD) begin
      for (int k = 2; k < n; k++) begin
        if (o.fa == 0 && hit(sh[d][k], sh[d][1].rs) && (!sh[d][k].ld || k == n - 1)) o.fa = k;
        if (o.fb == 0 && hit(sh[d][k], sh[d][1].rt) && (!sh[d][k].ld || k == n - 1)) o.fb = k;
      end
    end
    return o;
  endfunction

  task automatic adv_model();
    out_t o;
    int   n;
    for (int d = 0; d < 2; d++) begin
      n = (d == 0) ? 4 : 6;
      o = model_out(d, last_in);
      if (last_in.halt && sh[d][n-1].v) mhalt[d] = 1'b1;
      for (int k = n - 1; k >= 1; k--) begin
        if (o.fl[k]) sh[d][k] = '{default: 0};
        else if (o.en[k]) sh[d][k] = (k == 1) ? from_id(last_in) : sh[d][k-1];
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input in_t i);
    ihit = i.ihit; dhit = i.dhit; id_valid = i.idv; id_wen = i.wen;
    id_is_load = i.ld; id_is_mem = i.mem; id_jump = i.jump;
    ex_br_taken = i.br; wb_halt = i.halt;
    id_rs = 5'(i.rs); id_rt = 5'(i.rt); id_wsel = 5'(i.wsel);
  endtask

  task automatic check_all();
    out_t o;
    o = model_out(0, last_in);
    chk("m4.en", int'(en4), o.en);
    chk("m4.flush", int'(flush4), o.fl);
    chk("m4.pc_en", int'(pc4), int'(o.pc));
    chk("m4.fwd_a", int'(fa4), o.fa);
    chk("m4.fwd_b", int'(fb4), o.fb);
    chk("m4.halted", int'(h4), int'(mhalt[0]));
    o = model_out(1, last_in);
    chk("m6.en", int'(en6), o.en);
    chk("m6.flush", int'(flush6), o.fl);
    chk("m6.pc_en", int'(pc6), int'(o.pc));
    chk("m6.fwd_a", int'(fa6), o.fa);
    chk("m6.fwd_b", int'(fb6), o.fb);
    chk("m6.halted", int'(h6), int'(mhalt[1]));
  endtask

  task automatic step(input in_t i);
    @(posedge CLK);
    adv_model();
    @(negedge CLK);
    apply(i);
    last_in = i;
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(posedge CLK);
    adv_model();
    @(negedge CLK);
    apply(idle());
    last_in = idle();
    nRST = 1'b0;
    for (int d = 0; d < 2; d++) begin
      mhalt[d] = 1'b0;
      for (int k = 0; k < 8; k++) sh[d][k] = '{default: 0};
    end
    #1;
    chk("rst.en4", int'(en4), 0);
    chk("rst.flush4", int'(flush4), 15);
    chk("rst.pc4", int'(pc4), 0);
    chk("rst.fwd4", int'({fa4, fb4}), 0);
    chk("rst.halt4", int'(h4), 0);
    chk("rst.en6", int'(en6), 0);
    chk("rst.flush6", int'(flush6), 63);
    chk("rst.pc6", int'(pc6), 0);
    chk("rst.halt6", int'(h6), 0);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  function automatic in_t rand_in();
    in_t r;
    r = idle();
    r.ihit = $urandom_range(0, 9) < 8;
    r.dhit = $urandom_range(0, 3) != 0;
    r.idv  = $urandom_range(0, 9) < 8;
    r.wen  = $urandom_range(0, 9) < 7;
    r.ld   = $urandom_range(0, 9) < 3;
    r.mem  = r.ld || ($urandom_range(0, 4) == 0);
    r.jump = $urandom_range(0, 9) == 0;
    r.br   = $urandom_range(0, 9) == 0;
    r.rs   = int'($urandom_range(0, 3));
    r.rt   = int'($urandom_range(0, 3));
    r.wsel = int'($urandom_range(0, 3));
    return r;
  endfunction

  vec_t tbl [13];
  in_t  v;

  initial begin
    nRST = 1'b0;
    last_in = idle();
    apply(last_in);
    for (int d = 0; d < 2; d++) begin
      mhalt[d] = 1'b0;
      for (int k = 0; k < 8; k++) sh[d][k] = '{default: 0};
    end

    // Directed per-cycle vectors for the 4-register instance, from an empty pipeline.
    v = idle();                                  tbl[0]  = mkvec(v, 15, 0, 1);
    v = idle(); v.ihit = 0;                      tbl[1]  = mkvec(v, 15, 1, 0);
    v = idle(); v.ihit = 0; v.br = 1;            tbl[2]  = mkvec(v, 15, 3, 1);
    v = idle(); v.jump = 1;                      tbl[3]  = mkvec(v, 15, 1, 1);
    v = idle(); v.jump = 1; v.br = 1;            tbl[4]  = mkvec(v, 15, 3, 1);
    v = idle(); v.idv = 1; v.mem = 1; v.rs = 1; v.rt = 2;
                                                 tbl[5]  = mkvec(v, 15, 0, 1);
    v = idle();                                  tbl[6]  = mkvec(v, 15, 0, 1);
    v = idle(); v.dhit = 0;                      tbl[7]  = mkvec(v, 8, 8, 0);
    v = idle(); v.dhit = 0; v.br = 1; v.ihit = 0; tbl[8] = mkvec(v, 8, 8, 0);
    v = idle(); v.dhit = 0;                      tbl[9]  = mkvec(v, 8, 8, 0);
    v = idle();                                  tbl[10] = mkvec(v, 15, 0, 1);
    v = idle(); v.idv = 1; v.wen = 1; v.wsel = 5; v.ld = 1; v.mem = 1; v.rs = 1;
                                                 tbl[11] = mkvec(v, 15, 0, 1);
    v = idle(); v.idv = 1; v.wen = 1; v.wsel = 7; v.rs = 6; v.rt = 5;
                                                 tbl[12] = mkvec(v, 14, 2, 0);

    do_reset();
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].in);
      chk($sformatf("tbl%0d.en", i), int'(en4), tbl[i].en);
      chk($sformatf("tbl%0d.flush", i), int'(flush4), tbl[i].fl);
      chk($sformatf("tbl%0d.pc_en", i), int'(pc4), int'(tbl[i].pc));
    end

    // Reset with live entries, then the first clean fetch cycle.
    do_reset();
    step(idle());
    chk("post_rst.en4", int'(en4), 15);
    chk("post_rst.en6", int'(en6), 63);

`ifdef HAZARD_FORWARDING_EN
    do_reset();
    v = idle(); v.idv = 1; v.wen = 1; v.wsel = 3; v.rs = 1; v.rt = 2; step(v);
    v = idle(); v.idv = 1; v.wen = 1; v.wsel = 3; v.rs = 4; v.rt = 5; step(v);
    v = idle(); v.idv = 1; v.wen = 1; v.wsel = 6; v.rs = 3; v.rt = 0; step(v);
    v = idle(); v.idv = 1; v.rs = 0; v.rt = 3; step(v);
    chk("fwd.youngest", int'(fa4), 2);
    chk("fwd.r0_b", int'(fb4), 0);
    step(idle());
    chk("fwd.r0_a", int'(fa4), 0);
    chk("fwd.older_b", int'(fb4), 3);

    do_reset();
    v = idle(); v.idv = 1; v.wen = 1; v.wsel = 5; v.ld = 1; v.mem = 1; v.rs = 1; step(v);
    v = idle(); v.idv = 1; v.wen = 1; v.wsel = 7; v.rs = 6; v.rt = 5; step(v);
    chk("lu.pc_en", int'(pc4), 0);
    chk("lu.en", int'(en4), 14);
    chk("lu.flush", int'(flush4), 2);
    step(v);
    chk("lu.release_pc", int'(pc4), 1);
    chk("lu.release_en", int'(en4), 15);
    step(idle());
    chk("lu.fwd_b", int'(fb4), 3);
    chk("lu.fwd_a", int'(fa4), 0);
`else
    do_reset();
    v = idle(); v.idv = 1; v.wen = 1; v.wsel = 3; v.rs = 1; v.rt = 2; step(v);
    v = idle(); v.idv = 1; v.wen = 1; v.wsel = 6; v.rs = 3; v.rt = 0;
    for (int c = 0; c < 3; c++) begin
      step(v);
      chk($sformatf("raw%0d.pc_en", c), int'(pc4), 0);
      chk($sformatf("raw%0d.en", c), int'(en4), 14);
      chk($sformatf("raw%0d.flush", c), int'(flush4), 2);
    end
    step(v);
    chk("raw.release_pc", int'(pc4), 1);
    chk("raw.fwd_tied", int'(fa4), 0);
`endif

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else step(rand_in());
    end

    // Halt: one instruction walks to the last register of each instance.
    do_reset();
    v = idle(); v.idv = 1; step(v);
    step(idle());
    step(idle());
    v = idle(); v.halt = 1; step(v);
    chk("halt.pre4", int'(h4), 0);
    step(v);
    chk("halt.set4", int'(h4), 1);
    chk("halt.en4", int'(en4), 0);
    chk("halt.pc4", int'(pc4), 0);
    step(v);
    v = idle(); v.ihit = 0; v.dhit = 0; step(v);
    chk("halt.set6", int'(h6), 1);
    chk("halt.en6", int'(en6), 0);
    for (int i = 0; i < 4; i++) begin
      step(rand_in());
      chk($sformatf("halt.hold%0d.en4", i), int'(en4), 0);
      chk($sformatf("halt.hold%0d.pc6", i), int'(pc6), 0);
    end
    do_reset();
    step(idle());
    chk("halt.cleared4", int'(h4), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
